ual_seq: RTL

//  Sequential, width-parametrised arithmetic/logic unit for the processing unit datapath.

---
 rtl/ual_pkg.sv | 20 ++
 rtl/ual_mul_seq.sv | 70 +++++++
 rtl/ual_seq.sv | 113 +++++++++++
 3 files changed

// File: rtl/ual_pkg.sv
// Shared opcode and FSM encodings for the sequential ALU.
// No logic; constants and types only.
// No flow control; imported by ual_seq and ual_mul_seq.
package ual_pkg;

    localparam logic [2:0] UAL_NOR = 3'b000;
    localparam logic [2:0] UAL_AND = 3'b001;
    localparam logic [2:0] UAL_ADD = 3'b010;
    localparam logic [2:0] UAL_SUB = 3'b011;
    localparam logic [2:0] UAL_SHL = 3'b100;
    localparam logic [2:0] UAL_SHR = 3'b101;
    localparam logic [2:0] UAL_MUL = 3'b110;
    localparam logic [2:0] UAL_RSV = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ual_state_e;

endpackage

// File: rtl/ual_mul_seq.sv
// Iterative shift-add unsigned multiplier, one partial product per clock (built only with UAL_MUL_EN).
// Latency: load at edge N, last=1 in the cycle before edge N+WIDTH; prod_* are the next-step values.
// Backpressure: load is honoured only while idle; busy=1 for the whole run.
module ual_mul_seq
    import ual_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    localparam int CW = $clog2(WIDTH + 1);

    ual_state_e       state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH:0]   sum;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (load)          state_n = ST_RUN;
            ST_RUN:  if (cnt == CW'(1)) state_n = ST_IDLE;
            default:                    state_n = ST_IDLE;
        endcase
    end

    // Multiplier bits retire from lo_q's LSB while product bits shift in at its MSB.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        prod_hi = sum[WIDTH:1];
        prod_lo = {sum[0], lo_q[WIDTH-1:1]};
    end

    assign busy = (state == ST_RUN);
    assign last = busy && (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            mcand <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && load) begin
                mcand <= a;
                hi_q  <= '0;
                lo_q  <= b;
                cnt   <= CW'(WIDTH);
            end else if (state == ST_RUN) begin
                hi_q <= prod_hi;
                lo_q <= prod_lo;
                cnt  <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/ual_seq.sv
// Sequential ALU: NOR/AND/ADD/SUB/SHL/SHR in one cycle, MUL multi-cycle when UAL_MUL_EN is defined.
// Latency: single-cycle ops complete at the accept edge; MUL completes WIDTH edges after accept.
// Backpressure: start is accepted only when busy=0; starts while busy are dropped, not queued.
module ual_seq
    import ual_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       sel_UAL,
    input  logic [WIDTH-1:0] DATA_R1,
    input  logic [WIDTH-1:0] DATA_ACCU,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic [WIDTH-1:0] DATA_HI,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    logic             accept;
    logic             is_mul;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic [WIDTH:0]   wide;
    logic             mul_last;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;

    assign accept = start && !busy;

`ifdef UAL_MUL_EN
    assign is_mul = (sel_UAL == UAL_MUL);

    ual_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept && is_mul),
        .a       (DATA_ACCU),
        .b       (DATA_R1),
        .busy    (busy),
        .last    (mul_last),
        .prod_hi (mul_hi),
        .prod_lo (mul_lo)
    );
`else
    assign is_mul   = 1'b0;
    assign busy     = 1'b0;
    assign mul_last = 1'b0;
    assign mul_hi   = '0;
    assign mul_lo   = '0;
`endif

    // Without the multiplier, opcode 110 lands in the default (reserved) branch.
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        wide  = '0;
        case (sel_UAL)
            UAL_NOR: res = ~(DATA_ACCU | DATA_R1);
            UAL_AND: res = DATA_ACCU & DATA_R1;
            UAL_ADD: begin
                wide  = {1'b0, DATA_ACCU} + {1'b0, DATA_R1};
                res   = wide[WIDTH-1:0];
                res_c = wide[WIDTH];
            end
            UAL_SUB: begin
                wide  = {1'b0, DATA_ACCU} - {1'b0, DATA_R1};
                res   = wide[WIDTH-1:0];
                res_c = wide[WIDTH];
            end
            UAL_SHL: begin
                res   = {DATA_ACCU[WIDTH-2:0], 1'b0};
                res_c = DATA_ACCU[WIDTH-1];
            end
            UAL_SHR: begin
                res   = {1'b0, DATA_ACCU[WIDTH-1:1]};
                res_c = DATA_ACCU[0];
            end
            default: begin
                res   = '0;
                res_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DATA_OUT <= '0;
            DATA_HI  <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            done     <= 1'b0;
        end else if (mul_last) begin
            DATA_OUT <= mul_lo;
            DATA_HI  <= mul_hi;
            carry    <= |mul_hi;
            zero     <= (mul_lo == '0);
            done     <= 1'b1;
        end else if (accept && !is_mul) begin
            DATA_OUT <= res;
            DATA_HI  <= '0;
            carry    <= res_c;
            zero     <= (res == '0);
            done     <= 1'b1;
        end else begin
            done     <= 1'b0;
        end
    end

endmodule
